// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-Lite response codes and bridge FSM state encoding
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_WR_ADDR = 3'd1;
  localparam logic [2:0] ENC_WR_DATA = 3'd2;
  localparam logic [2:0] ENC_WR_RESP = 3'd3;
  localparam logic [2:0] ENC_RD_ADDR = 3'd4;
  localparam logic [2:0] ENC_RD_DATA = 3'd5;
  localparam logic [2:0] ENC_RSP     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ENC_IDLE,
    S_WR_ADDR = ENC_WR_ADDR,
    S_WR_DATA = ENC_WR_DATA,
    S_WR_RESP = ENC_WR_RESP,
    S_RD_ADDR = ENC_RD_ADDR,
    S_RD_DATA = ENC_RD_DATA,
    S_RSP     = ENC_RSP
  } bridge_state_e;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// rtl/axi_lite_master_bridge.sv - single-beat command/response to AXI4-Lite master bridge
module axi_lite_master_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [3:0]            WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  bridge_state_e         state_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wstrb_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [1:0]            rsp_resp_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  // One transaction at a time: AW, then W, then B (or AR, then R), then hand the response back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              state_q   <= S_WR_ADDR;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= S_RD_ADDR;
            end
          end
        end
        S_WR_ADDR: begin
          // W waits for the AW handshake so address-first slaves are safe.
          if (AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (WREADY) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= BRESP;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (RVALID) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= RRESP;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
